// File: rtl/thread_register_file.sv
// Per-thread 16-entry register file: R0-R12 general purpose, R13-R15 read-only
// block_id / block_dim / thread_id. Operands are latched in REQUEST, writeback lands in UPDATE.
module thread_register_file #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [DATA_BITS-1:0] decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_FETCH   = 3'b001,
        ST_DECODE  = 3'b010,
        ST_REQUEST = 3'b011,
        ST_WAIT    = 3'b100,
        ST_EXECUTE = 3'b101,
        ST_UPDATE  = 3'b110,
        ST_DONE    = 3'b111
    } core_state_e;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_LSU = 2'b01,
        SRC_IMM = 2'b10,
        SRC_RSV = 2'b11
    } reg_src_e;

    localparam logic [3:0] REG_BLOCK_ID  = 4'd13;
    localparam logic [3:0] REG_BLOCK_DIM = 4'd14;
    localparam logic [3:0] REG_THREAD_ID = 4'd15;

    logic [DATA_BITS-1:0] regs_q [16];
    logic [DATA_BITS-1:0] regs_d [16];
    logic [DATA_BITS-1:0] rs_q, rs_d;
    logic [DATA_BITS-1:0] rt_q, rt_d;

    core_state_e state;
    reg_src_e    src;

    assign state = core_state_e'(core_state);
    assign src   = reg_src_e'(decoded_reg_input_mux);

    // NOTE: every variable gets its hold value first so no path can infer a latch.
    always_comb begin
        regs_d = regs_q;
        rs_d   = rs_q;
        rt_d   = rt_q;
        if (enable) begin
            if (state == ST_REQUEST) begin
                rs_d = regs_q[decoded_rs_address];
                rt_d = regs_q[decoded_rt_address];
            end
            if (state == ST_UPDATE && decoded_reg_write_enable
                && decoded_rd_address < REG_BLOCK_ID) begin
                case (src)
                    SRC_ALU: regs_d[decoded_rd_address] = alu_out;
                    SRC_LSU: regs_d[decoded_rd_address] = lsu_out;
                    SRC_IMM: regs_d[decoded_rd_address] = decoded_immediate;
                    default: ;
                endcase
            end
            // Refresh last so a same-cycle write aimed at R13 can never win.
            regs_d[REG_BLOCK_ID] = block_id;
        end
    end

    // NOTE: the array is reset because R14/R15 must come up holding their constants
    // and R0-R12 are architecturally defined as zero after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 13; i++) regs_q[i] <= '0;
            regs_q[REG_BLOCK_ID]  <= '0;
            regs_q[REG_BLOCK_DIM] <= DATA_BITS'(THREADS_PER_BLOCK);
            regs_q[REG_THREAD_ID] <= DATA_BITS'(THREAD_ID);
            rs_q <= '0;
            rt_q <= '0;
        end else begin
            regs_q <= regs_d;
            rs_q   <= rs_d;
            rt_q   <= rt_d;
        end
    end

    assign rs = rs_q;
    assign rt = rt_q;

endmodule

// File: tb/tb_thread_register_file.sv
// Directed bench for thread_register_file: expected operand pairs are queued when a
// read is issued and compared after the edge that latches them.
module tb_thread_register_file;

    localparam int TPB = 4;
    localparam int TID = 2;
    localparam int DW  = 8;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [DW-1:0] block_id;
    logic [2:0]    core_state;
    logic [3:0]    rd_addr, rs_addr, rt_addr;
    logic          we;
    logic [1:0]    mux;
    logic [DW-1:0] imm, alu_out, lsu_out;
    logic [DW-1:0] rs, rt;

    typedef struct {
        string         tag;
        logic [DW-1:0] rs;
        logic [DW-1:0] rt;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    thread_register_file #(
        .THREADS_PER_BLOCK(TPB),
        .THREAD_ID(TID),
        .DATA_BITS(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .block_id(block_id),
        .core_state(core_state),
        .decoded_rd_address(rd_addr),
        .decoded_rs_address(rs_addr),
        .decoded_rt_address(rt_addr),
        .decoded_reg_write_enable(we),
        .decoded_reg_input_mux(mux),
        .decoded_immediate(imm),
        .alu_out(alu_out),
        .lsu_out(lsu_out),
        .rs(rs),
        .rt(rt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare the oldest queued expectation against the current operand outputs.
    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            e = sb.pop_front();
            check({e.tag, "_rs"}, rs, e.rs);
            check({e.tag, "_rt"}, rt, e.rt);
        end
    endtask

    task automatic request(input string tag, input logic [3:0] a_rs, input logic [3:0] a_rt,
                           input logic [DW-1:0] e_rs, input logic [DW-1:0] e_rt);
        exp_t e;
        core_state = 3'b011;
        rs_addr    = a_rs;
        rt_addr    = a_rt;
        e.tag = tag;
        e.rs  = e_rs;
        e.rt  = e_rt;
        sb.push_back(e);
        tick();
        pop_compare();
        core_state = 3'b100;
    endtask

    task automatic drive_write(input logic [2:0] st, input logic [3:0] rd, input logic [1:0] m,
                               input logic [DW-1:0] v_imm, input logic [DW-1:0] v_alu,
                               input logic [DW-1:0] v_lsu);
        core_state = st;
        rd_addr    = rd;
        we         = 1'b1;
        mux        = m;
        imm        = v_imm;
        alu_out    = v_alu;
        lsu_out    = v_lsu;
        tick();
        we         = 1'b0;
        core_state = 3'b000;
    endtask

    initial begin
        exp_t e;
        reset = 1'b0; enable = 1'b1; block_id = '0; core_state = 3'b000;
        rd_addr = '0; rs_addr = '0; rt_addr = '0; we = 1'b0; mux = 2'b00;
        imm = '0; alu_out = '0; lsu_out = '0;

        // Reset with junk on the operand outputs' sources must clear rs/rt.
        core_state = 3'b011; rs_addr = 4'd14; rt_addr = 4'd15;
        e.tag = "reset"; e.rs = 8'h00; e.rt = 8'h00; sb.push_back(e);
        tick();
        pop_compare();
        reset = 1'b1; core_state = 3'b000;
        tick();

        request("special_dim_tid", 4'd14, 4'd15, 8'd4, 8'd2);
        request("r3_zero", 4'd3, 4'd3, 8'h00, 8'h00);

        drive_write(3'b110, 4'd5, 2'b10, 8'h3C, 8'hA5, 8'h5A);
        request("wr_imm", 4'd5, 4'd5, 8'h3C, 8'h3C);
        drive_write(3'b110, 4'd5, 2'b00, 8'h12, 8'h81, 8'h34);
        request("wr_alu", 4'd5, 4'd5, 8'h81, 8'h81);
        drive_write(3'b110, 4'd5, 2'b01, 8'h12, 8'h56, 8'hFF);
        request("wr_lsu", 4'd5, 4'd5, 8'hFF, 8'hFF);

        drive_write(3'b110, 4'd15, 2'b10, 8'h77, 8'h77, 8'h77);
        request("r15_ro", 4'd15, 4'd14, 8'd2, 8'd4);

        drive_write(3'b110, 4'd6, 2'b10, 8'h22, 8'h00, 8'h00);
        drive_write(3'b110, 4'd6, 2'b11, 8'h99, 8'h98, 8'h97);
        request("mux_rsv", 4'd6, 4'd5, 8'h22, 8'hFF);
        drive_write(3'b101, 4'd6, 2'b10, 8'h99, 8'h98, 8'h97);
        request("we_in_exec", 4'd6, 4'd6, 8'h22, 8'h22);

        block_id = 8'd9;
        tick();
        request("r13_refresh", 4'd13, 4'd0, 8'd9, 8'h00);
        drive_write(3'b110, 4'd13, 2'b10, 8'h55, 8'h55, 8'h55);
        request("r13_ro", 4'd13, 4'd13, 8'd9, 8'd9);

        // Disabled: all stimulus must be ignored and rs/rt keep 9/9.
        enable = 1'b0;
        block_id = 8'h20;
        core_state = 3'b011; rs_addr = 4'd5; rt_addr = 4'd6;
        e.tag = "dis_req"; e.rs = 8'd9; e.rt = 8'd9; sb.push_back(e);
        tick();
        pop_compare();
        core_state = 3'b110; rd_addr = 4'd5; we = 1'b1; mux = 2'b10; imm = 8'h44;
        e.tag = "dis_upd"; e.rs = 8'd9; e.rt = 8'd9; sb.push_back(e);
        tick();
        pop_compare();
        we = 1'b0; core_state = 3'b000;
        enable = 1'b1;
        request("reen_hold", 4'd5, 4'd13, 8'hFF, 8'd9);
        request("reen_r13", 4'd13, 4'd13, 8'h20, 8'h20);

        // Reset landing on an UPDATE cycle discards the write.
        drive_write(3'b110, 4'd5, 2'b10, 8'h3C, 8'h00, 8'h00);
        request("pre_rst", 4'd5, 4'd5, 8'h3C, 8'h3C);
        core_state = 3'b110; rd_addr = 4'd5; we = 1'b1; mux = 2'b10; imm = 8'h11;
        reset = 1'b0;
        e.tag = "rst_mid"; e.rs = 8'h00; e.rt = 8'h00; sb.push_back(e);
        tick();
        pop_compare();
        reset = 1'b1; we = 1'b0; core_state = 3'b000;
        request("post_rst", 4'd5, 4'd14, 8'h00, 8'd4);
        request("post_rst_r13", 4'd13, 4'd15, 8'h20, 8'd2);

        if (sb.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
